// File: rtl/ysyx_22040750_if_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave).
interface ysyx_22040750_if_fetch_if;
  logic        O_imem_req_valid;
  logic        I_imem_req_ready;
  logic [31:0] O_imem_addr;
  logic        I_imem_rsp_valid;
  logic [31:0] I_imem_rsp_data;

  modport master (
    output O_imem_req_valid,
    output O_imem_addr,
    input  I_imem_req_ready,
    input  I_imem_rsp_valid,
    input  I_imem_rsp_data
  );

  modport slave (
    input  O_imem_req_valid,
    input  O_imem_addr,
    output I_imem_req_ready,
    output I_imem_rsp_valid,
    output I_imem_rsp_data
  );
endinterface

// File: rtl/ysyx_22040750_if_fetch.sv
// Instruction-fetch stage: single-outstanding imem fetch, holds the returned word
// until IF_ID takes it, and squashes wrong-path fetches on redirect.
module ysyx_22040750_if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic                            I_sys_clk,
  input  logic                            I_rst,
  ysyx_22040750_if_fetch_if.master        imem,
  input  logic                            I_redirect,
  input  logic [31:0]                     I_redirect_pc,
  input  logic                            I_timer_intr,
  input  logic                            I_IF_ID_allowin,
  output logic                            O_IF_valid,
  output logic [31:0]                     O_pc,
  output logic [31:0]                     O_inst,
  output logic                            O_timer_intr,
  output logic                            O_IF_jmp
);

  typedef enum logic [1:0] {REQ, WAIT, DROP, HOLD} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        pend, pend_nxt;
  logic        accept, transfer, capture, drop_held;
  logic        redirect_pc_unused;

  assign redirect_pc_unused = ^I_redirect_pc[1:0];

  assign accept   = (state == REQ) & imem.I_imem_req_ready;
  assign transfer = (state == HOLD) & I_IF_ID_allowin;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    capture   = 1'b0;
    drop_held = 1'b0;
    pend_nxt  = pend;
    case (state)
      REQ: begin
        if (accept) state_nxt = I_redirect ? DROP : WAIT;
      end
      WAIT: begin
        if (imem.I_imem_rsp_valid) begin
          if (I_redirect) begin
            state_nxt = REQ;
          end else begin
            state_nxt = HOLD;
            capture   = 1'b1;
          end
        end else if (I_redirect) begin
          state_nxt = DROP;
        end
      end
      DROP: begin
        // A response still in flight belongs to the old path; swallow it.
        if (imem.I_imem_rsp_valid) state_nxt = REQ;
      end
      HOLD: begin
        if (I_redirect) begin
          state_nxt = REQ;
          drop_held = 1'b1;
        end else if (transfer) begin
          state_nxt = REQ;
          pc_nxt    = pc + 32'd4;
          if (O_timer_intr) pend_nxt = 1'b0;
        end
      end
      default: state_nxt = REQ;
    endcase
    if (I_redirect) pc_nxt = {I_redirect_pc[31:2], 2'b00};
    // A new request arriving in the clearing cycle must not be lost.
    if (I_timer_intr) pend_nxt = 1'b1;
  end

  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      state        <= REQ;
      pc           <= RESET_PC;
      pend         <= 1'b0;
      O_pc         <= 32'd0;
      O_inst       <= 32'd0;
      O_timer_intr <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      pend  <= pend_nxt;
      if (capture) begin
        O_pc         <= pc;
        O_inst       <= imem.I_imem_rsp_data;
        O_timer_intr <= pend | I_timer_intr;
      end else if (drop_held) begin
        O_timer_intr <= 1'b0;
      end
    end
  end

  assign O_IF_valid            = (state == HOLD);
  assign imem.O_imem_req_valid = (state == REQ);
  assign imem.O_imem_addr      = pc;
  assign O_IF_jmp              = I_redirect;

endmodule

// File: tb/tb_ysyx_22040750_if_fetch.sv
// Directed bench for the fetch stage with an in-bench latency-configurable imem
// and address/output scoreboards.
module tb_ysyx_22040750_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        timer;
  logic        allowin;
  logic        if_valid;
  logic [31:0] o_pc;
  logic [31:0] o_inst;
  logic        o_intr;
  logic        if_jmp;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int lat      = 1;

  typedef struct packed {
    logic [31:0] pc;
    logic        intr;
  } exp_t;

  logic [31:0] exp_addr[$];
  exp_t        exp_out[$];

  ysyx_22040750_if_fetch_if mif ();

  ysyx_22040750_if_fetch dut (
    .I_sys_clk       (clk),
    .I_rst           (rst),
    .imem            (mif),
    .I_redirect      (redirect),
    .I_redirect_pc   (redirect_pc),
    .I_timer_intr    (timer),
    .I_IF_ID_allowin (allowin),
    .O_IF_valid      (if_valid),
    .O_pc            (o_pc),
    .O_inst          (o_inst),
    .O_timer_intr    (o_intr),
    .O_IF_jmp        (if_jmp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max);
    for (int i = 0; i < max && if_valid !== 1'b1; i++) tick();
    chk1("wait_valid_timeout", if_valid, 1'b1);
  endtask

  task automatic push(input logic [31:0] a, input logic intr, input bit delivered);
    exp_addr.push_back(a);
    if (delivered) exp_out.push_back('{pc: a, intr: intr});
  endtask

  // Instruction memory: decides at each negedge what the next posedge sees.
  logic        m_busy = 1'b0;
  int          m_cnt  = 0;
  logic [31:0] m_addr = 32'd0;

  initial begin
    mif.I_imem_rsp_valid = 1'b0;
    mif.I_imem_rsp_data  = 32'd0;
  end

  always @(negedge clk) begin
    mif.I_imem_rsp_valid = 1'b0;
    if (rst === 1'b1) begin
      m_busy = 1'b0;
    end else begin
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          mif.I_imem_rsp_valid = 1'b1;
          mif.I_imem_rsp_data  = memf(m_addr);
          m_busy               = 1'b0;
        end
      end
      if (mif.O_imem_req_valid === 1'b1 && mif.I_imem_req_ready === 1'b1) begin
        chk1("one_outstanding", m_busy, 1'b0);
        n_assert++;
        assert (exp_addr.size() > 0) else begin
          n_fail++;
          $error("FAIL unexpected_req: observed addr %h, required no request", mif.O_imem_addr);
        end
        if (exp_addr.size() > 0) chk32("fetch_addr", mif.O_imem_addr, exp_addr.pop_front());
        m_busy = 1'b1;
        m_addr = mif.O_imem_addr;
        m_cnt  = lat;
      end
    end
  end

  // Output scoreboard: every clean transfer to IF_ID must match the next expected word.
  always @(negedge clk) begin
    if (if_valid === 1'b1 && allowin === 1'b1 && redirect === 1'b0 && rst === 1'b0) begin
      n_assert++;
      assert (exp_out.size() > 0) else begin
        n_fail++;
        $error("FAIL unexpected_valid: observed pc %h, required no instruction", o_pc);
      end
      if (exp_out.size() > 0) begin
        exp_t e;
        e = exp_out.pop_front();
        chk32("xfer_pc", o_pc, e.pc);
        chk32("xfer_inst", o_inst, memf(e.pc));
        chk1("xfer_intr", o_intr, e.intr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    logic [31:0] hold_pc, hold_inst;
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'd0; timer = 1'b0;
    allowin = 1'b1; mif.I_imem_req_ready = 1'b1; lat = 1;
    repeat (2) tick();

    chk1("rst_valid", if_valid, 1'b0);
    chk32("rst_pc", o_pc, 32'd0);
    chk32("rst_inst", o_inst, 32'd0);
    chk1("rst_intr", o_intr, 1'b0);
    chk1("rst_req_valid", mif.O_imem_req_valid, 1'b1);
    chk32("rst_addr", mif.O_imem_addr, 32'h8000_0000);

    // Back-to-back fetches with single-cycle memory.
    push(32'h8000_0000, 1'b0, 1'b1);
    push(32'h8000_0004, 1'b0, 1'b1);
    push(32'h8000_0008, 1'b0, 1'b1);
    rst = 1'b0;
    wait_valid(10);
    c0 = cyc;
    chk32("first_pc", o_pc, 32'h8000_0000);
    tick();
    wait_valid(10);
    chk32("spacing_1", 32'(cyc - c0), 32'd3);
    c0 = cyc;
    tick();
    wait_valid(10);
    chk32("spacing_2", 32'(cyc - c0), 32'd3);
    tick();

    // IF_ID stalls: held word and outputs stay put, no new request.
    allowin = 1'b0;
    push(32'h8000_000C, 1'b0, 1'b1);
    wait_valid(10);
    hold_pc = o_pc;
    hold_inst = o_inst;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1("stall_valid", if_valid, 1'b1);
      chk32("stall_pc", o_pc, hold_pc);
      chk32("stall_inst", o_inst, hold_inst);
      chk1("stall_no_req", mif.O_imem_req_valid, 1'b0);
    end
    push(32'h8000_0010, 1'b0, 1'b1);
    allowin = 1'b1;
    tick();
    wait_valid(10);
    chk32("resume_pc", o_pc, 32'h8000_0010);
    tick();

    // Redirect while waiting: in-flight word is stale.
    lat = 2;
    push(32'h8000_0014, 1'b0, 1'b0);
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h8000_0103;
    #1;
    chk1("jmp_in_wait", if_jmp, 1'b1);
    tick();
    redirect = 1'b0;
    chk1("drop_no_req", mif.O_imem_req_valid, 1'b0);
    chk1("drop_no_valid", if_valid, 1'b0);
    lat = 1;
    push(32'h8000_0100, 1'b0, 1'b1);
    tick();
    chk1("after_drop_no_valid", if_valid, 1'b0);
    chk32("after_drop_addr", mif.O_imem_addr, 32'h8000_0100);
    wait_valid(10);
    chk32("target_pc", o_pc, 32'h8000_0100);
    tick();

    // Redirect in HOLD with allowin: word becomes a bubble.
    push(32'h8000_0104, 1'b0, 1'b0);
    wait_valid(10);
    redirect = 1'b1;
    redirect_pc = 32'h8000_0200;
    #1;
    chk1("jmp_in_hold", if_jmp, 1'b1);
    tick();
    redirect = 1'b0;
    #1;
    chk1("jmp_clear", if_jmp, 1'b0);
    chk1("hold_redir_valid", if_valid, 1'b0);
    chk1("hold_redir_req", mif.O_imem_req_valid, 1'b1);
    chk32("hold_redir_addr", mif.O_imem_addr, 32'h8000_0200);

    // Timer pulse during WAIT tags the word; a clean transfer clears it.
    push(32'h8000_0200, 1'b1, 1'b1);
    tick();
    timer = 1'b1;
    tick();
    timer = 1'b0;
    chk1("intr_valid", if_valid, 1'b1);
    chk1("intr_attached", o_intr, 1'b1);
    tick();
    push(32'h8000_0204, 1'b0, 1'b1);
    wait_valid(10);
    chk1("intr_cleared", o_intr, 1'b0);
    tick();

    // Redirect drops a tagged word but the pending interrupt survives.
    push(32'h8000_0208, 1'b1, 1'b0);
    tick();
    timer = 1'b1;
    tick();
    timer = 1'b0;
    chk1("intr_attached_2", o_intr, 1'b1);
    redirect = 1'b1;
    redirect_pc = 32'h8000_0300;
    tick();
    redirect = 1'b0;
    chk1("intr_dropped", o_intr, 1'b0);
    push(32'h8000_0300, 1'b1, 1'b1);
    wait_valid(10);
    chk1("pend_kept", o_intr, 1'b1);
    tick();
    push(32'h8000_0304, 1'b0, 1'b1);
    wait_valid(10);
    chk1("pend_cleared", o_intr, 1'b0);
    tick();

    // Reset while a fetch is outstanding.
    lat = 3;
    push(32'h8000_0308, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    lat = 1;
    chk1("wait_rst_valid", if_valid, 1'b0);
    chk1("wait_rst_req", mif.O_imem_req_valid, 1'b1);
    chk32("wait_rst_addr", mif.O_imem_addr, 32'h8000_0000);
    chk32("wait_rst_pc", o_pc, 32'd0);
    push(32'h8000_0000, 1'b0, 1'b1);
    wait_valid(10);
    tick();

    // Redirect while not accepted, then PC wrap past the top of memory.
    mif.I_imem_req_ready = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect = 1'b0;
    chk1("req_redir_req", mif.O_imem_req_valid, 1'b1);
    chk32("req_redir_addr", mif.O_imem_addr, 32'hFFFF_FFFC);
    push(32'hFFFF_FFFC, 1'b0, 1'b1);
    mif.I_imem_req_ready = 1'b1;
    wait_valid(10);
    tick();
    chk32("wrap_addr", mif.O_imem_addr, 32'd0);
    push(32'd0, 1'b0, 1'b1);
    wait_valid(10);
    tick();
    mif.I_imem_req_ready = 1'b0;
    repeat (3) tick();

    chk32("addr_queue_empty", 32'(exp_addr.size()), 32'd0);
    chk32("out_queue_empty", 32'(exp_out.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
